tone_generator_multi: RTL and testbench

Time-multiplexed, N-voice successor to the single-voice phase-accumulator tone generator. Per-voice state lives in register arrays: accumulator, frequency, pulse width, control and noise LFSR. One shared waveform datapath serves all voices. Each sample_tick starts one sweep over voices 0..VOICES-1, one voice per clock, emitting one tagged sample per voice. Adds behaviour the single-voice block lacks: hard sync, XOR ring modulation from the preceding voice, per-voice noise, and tick-overrun detection. The block feeds the per-voice envelope/mixer stage.

---
 rtl/tone_gen_pkg.sv | 29 ++
 rtl/tone_wave_shaper.sv | 48 ++++
 rtl/tone_generator_multi.sv | 169 ++++++++++++++++
 tb/tb_tone_generator_multi.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_gen_pkg.sv
// Shared constants, state encoding and LFSR step for the multi-voice tone generator.
package tone_gen_pkg;

   localparam logic [1:0] CFG_FREQ = 2'd0;
   localparam logic [1:0] CFG_PW   = 2'd1;
   localparam logic [1:0] CFG_CTRL = 2'd2;

   localparam int WAVE_TRI   = 0;
   localparam int WAVE_SAW   = 1;
   localparam int WAVE_PULSE = 2;
   localparam int WAVE_NOISE = 3;
   localparam int CTRL_SYNC  = 4;
   localparam int CTRL_RING  = 5;
   localparam int CTRL_W     = 6;

   localparam int                LFSR_W    = 23;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   // Fibonacci step: shift left, feed back taps 22 and 17.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[22] ^ s[17]};
   endfunction

endpackage

// File: rtl/tone_wave_shaper.sv
// Combinational waveform stage shared by all voices: ANDs together the enabled
// triangle/saw/pulse/noise terms derived from the updated phase.
module tone_wave_shaper
   import tone_gen_pkg::*;
#(
   parameter int ACCUMULATOR_BITS = 24,
   parameter int PULSEWIDTH_BITS  = 12,
   parameter int OUTPUT_BITS      = 12
) (
   input  logic [ACCUMULATOR_BITS-1:0] i_acc,
   input  logic [PULSEWIDTH_BITS-1:0]  i_pulse_width,
   input  logic [CTRL_W-1:0]           i_ctrl,
   input  logic [LFSR_W-1:0]           i_lfsr,
   input  logic                        i_src_msb,
   output logic [OUTPUT_BITS-1:0]      o_sample
);

   localparam int MSB = ACCUMULATOR_BITS - 1;

   logic [OUTPUT_BITS-1:0] w_noise;
   logic [OUTPUT_BITS-1:0] w_pulse;
   logic [OUTPUT_BITS-1:0] w_saw;
   logic [OUTPUT_BITS-1:0] w_tri;
   logic                   w_tri_inv;
   logic [OUTPUT_BITS-1:0] w_mix;
   logic                   w_unused;

   always_comb begin
      w_noise   = i_lfsr[LFSR_W-1 -: OUTPUT_BITS];
      w_pulse   = {OUTPUT_BITS{i_acc[MSB -: PULSEWIDTH_BITS] > i_pulse_width}};
      w_saw     = i_acc[MSB -: OUTPUT_BITS];
      w_tri_inv = i_acc[MSB] ^ (i_ctrl[CTRL_RING] & i_src_msb);
      w_tri     = i_acc[MSB-1 -: OUTPUT_BITS] ^ {OUTPUT_BITS{w_tri_inv}};

      w_mix = '1;
      if (i_ctrl[WAVE_NOISE]) w_mix = w_mix & w_noise;
      if (i_ctrl[WAVE_PULSE]) w_mix = w_mix & w_pulse;
      if (i_ctrl[WAVE_SAW])   w_mix = w_mix & w_saw;
      if (i_ctrl[WAVE_TRI])   w_mix = w_mix & w_tri;

      // With no waveform selected the voice is silent rather than all-ones.
      o_sample = (i_ctrl[WAVE_NOISE:WAVE_TRI] == 4'b0000) ? '0 : w_mix;
   end

   // Low phase/LFSR bits and the sync bit are not part of the waveform.
   assign w_unused = ^{i_acc, i_lfsr, i_ctrl[CTRL_SYNC]};

endmodule

// File: rtl/tone_generator_multi.sv
// Time-multiplexed N-voice phase-accumulator tone generator with ring mod, noise
// and optional hard sync (enabled by defining TONE_GENERATOR_MULTI_SYNC_EN).
module tone_generator_multi
   import tone_gen_pkg::*;
#(
   parameter int VOICES           = 4,
   parameter int FREQ_BITS        = 16,
   parameter int PULSEWIDTH_BITS  = 12,
   parameter int OUTPUT_BITS      = 12,
   parameter int ACCUMULATOR_BITS = 24,
   parameter int NOISE_CLK_BIT    = 19
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_tick,
   input  logic                       cfg_we,
   input  logic [$clog2(VOICES)-1:0]  cfg_voice,
   input  logic [1:0]                 cfg_addr,
   input  logic [FREQ_BITS-1:0]       cfg_data,
   output logic [OUTPUT_BITS-1:0]     dout,
   output logic [$clog2(VOICES)-1:0]  dout_voice,
   output logic                       dout_valid,
   output logic                       busy,
   output logic                       overrun
);

   localparam int VW  = $clog2(VOICES);
   localparam int MSB = ACCUMULATOR_BITS - 1;

   state_t                      r_state;
   state_t                      w_next_state;
   logic [VW-1:0]               r_vidx;
   logic                        w_proc;
   logic                        w_last;

   logic [ACCUMULATOR_BITS-1:0] r_acc  [VOICES];
   logic [FREQ_BITS-1:0]        r_freq [VOICES];
   logic [PULSEWIDTH_BITS-1:0]  r_pw   [VOICES];
   logic [CTRL_W-1:0]           r_ctrl [VOICES];
   logic [LFSR_W-1:0]           r_lfsr [VOICES];
   logic                        r_rise [VOICES];

   logic [VW-1:0]               w_src;
   logic [ACCUMULATOR_BITS-1:0] w_acc_old;
   logic [ACCUMULATOR_BITS-1:0] w_acc_new;
   logic                        w_sync_hit;
   logic                        w_rise;
   logic                        w_noise_clk;
   logic [LFSR_W-1:0]           w_lfsr_new;
   logic [CTRL_W-1:0]           w_ctrl;
   logic                        w_src_msb;
   logic [OUTPUT_BITS-1:0]      w_sample;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (sample_tick) w_next_state = ST_SWEEP;
         ST_SWEEP: if (w_last)      w_next_state = ST_IDLE;
         default:                   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_proc = (r_state == ST_SWEEP);
      w_last = w_proc && (r_vidx == VW'(VOICES - 1));
      busy   = w_proc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_vidx <= '0;
      end else if (w_proc) begin
         r_vidx <= w_last ? '0 : r_vidx + VW'(1);
      end else if (sample_tick) begin
         r_vidx <= '0;
      end
   end

   // Ticks landing mid-sweep are dropped; the flag stays up until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          overrun <= 1'b0;
      else if (sample_tick && w_proc)    overrun <= 1'b1;
   end

   // Sync/ring source is the preceding voice; voice 0 wraps to the last voice.
   always_comb begin
      w_src       = (r_vidx == '0) ? VW'(VOICES - 1) : r_vidx - VW'(1);
      w_acc_old   = r_acc[r_vidx];
      w_ctrl      = r_ctrl[r_vidx];
      w_src_msb   = r_acc[w_src][MSB];
`ifdef TONE_GENERATOR_MULTI_SYNC_EN
      w_sync_hit  = w_ctrl[CTRL_SYNC] & r_rise[w_src];
`else
      w_sync_hit  = 1'b0;
`endif
      w_acc_new   = w_sync_hit ? '0 : w_acc_old + ACCUMULATOR_BITS'(r_freq[r_vidx]);
      w_rise      = ~w_acc_old[MSB] & w_acc_new[MSB];
      w_noise_clk = ~w_acc_old[NOISE_CLK_BIT] & w_acc_new[NOISE_CLK_BIT];
      w_lfsr_new  = w_noise_clk ? lfsr_step(r_lfsr[r_vidx]) : r_lfsr[r_vidx];
   end

`ifndef TONE_GENERATOR_MULTI_SYNC_EN
   // Rise flags are still kept so the storage matches the sync build.
   logic w_unused_sync;
   assign w_unused_sync = w_ctrl[CTRL_SYNC] & r_rise[w_src];
`endif

   tone_wave_shaper #(
      .ACCUMULATOR_BITS (ACCUMULATOR_BITS),
      .PULSEWIDTH_BITS  (PULSEWIDTH_BITS),
      .OUTPUT_BITS      (OUTPUT_BITS)
   ) u_shaper (
      .i_acc         (w_acc_new),
      .i_pulse_width (r_pw[r_vidx]),
      .i_ctrl        (w_ctrl),
      .i_lfsr        (w_lfsr_new),
      .i_src_msb     (w_src_msb),
      .o_sample      (w_sample)
   );

   // Voice state: sweep updates and config writes touch disjoint fields,
   // so the voice being processed always sees its pre-write settings.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < VOICES; i++) begin
            r_acc[i]  <= '0;
            r_freq[i] <= '0;
            r_pw[i]   <= '0;
            r_ctrl[i] <= '0;
            r_lfsr[i] <= LFSR_SEED;
            r_rise[i] <= 1'b0;
         end
      end else begin
         if (w_proc) begin
            r_acc[r_vidx]  <= w_acc_new;
            r_rise[r_vidx] <= w_rise;
            r_lfsr[r_vidx] <= w_lfsr_new;
         end
         if (cfg_we) begin
            case (cfg_addr)
               CFG_FREQ: r_freq[cfg_voice] <= cfg_data;
               CFG_PW:   r_pw[cfg_voice]   <= cfg_data[PULSEWIDTH_BITS-1:0];
               CFG_CTRL: r_ctrl[cfg_voice] <= cfg_data[CTRL_W-1:0];
               default:  ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout       <= '0;
         dout_voice <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= w_proc;
         if (w_proc) begin
            dout       <= w_sample;
            dout_voice <= r_vidx;
         end
      end
   end

endmodule

// File: tb/tb_tone_generator_multi.sv
// Scoreboard bench for tone_generator_multi: a behavioural voice model predicts
// every tagged sample and its arrival cycle; a monitor pops and compares.
module tb_tone_generator_multi;

   localparam int V       = 4;
   localparam int VW      = $clog2(V);
   localparam int ACC_MOD = 1 << 24;
   localparam int HALF    = 1 << 23;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sample_tick = 1'b0;
   logic          cfg_we = 1'b0;
   logic [VW-1:0] cfg_voice = '0;
   logic [1:0]    cfg_addr = '0;
   logic [15:0]   cfg_data = '0;
   logic [11:0]   dout;
   logic [VW-1:0] dout_voice;
   logic          dout_valid;
   logic          busy;
   logic          overrun;

   tone_generator_multi #(
      .VOICES(V), .FREQ_BITS(16), .PULSEWIDTH_BITS(12),
      .OUTPUT_BITS(12), .ACCUMULATOR_BITS(24), .NOISE_CLK_BIT(19)
   ) dut (
      .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_we(cfg_we),
      .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .dout(dout), .dout_voice(dout_voice), .dout_valid(dout_valid),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int voice;
      int data;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   last_dout [V];

   // Reference voice state
   int m_acc [V];
   int m_freq[V];
   int m_pw  [V];
   int m_ctrl[V];
   int m_lfsr[V];
   bit m_rise[V];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (rst && dout_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: voice %0d data 0x%0h, nothing expected", dout_voice, dout);
         end else begin
            mon_e = sb.pop_front();
            check("dout_voice", int'(dout_voice), mon_e.voice);
            check("dout", int'(dout), mon_e.data);
            check("dout_cycle", cyc, mon_e.cyc);
         end
         last_dout[dout_voice] = int'(dout);
      end
   end

   function automatic int lfsr_next(input int s);
      int fb;
      fb = ((s >> 22) ^ (s >> 17)) & 1;
      return ((s << 1) | fb) & 32'h7FFFFF;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < V; v++) begin
         m_acc[v] = 0; m_freq[v] = 0; m_pw[v] = 0; m_ctrl[v] = 0;
         m_lfsr[v] = 32'h7FFFF8; m_rise[v] = 1'b0;
      end
   endtask

   task automatic model_write(input int v, input int a, input int d);
      case (a)
         0: m_freq[v] = d & 32'hFFFF;
         1: m_pw[v]   = d & 32'hFFF;
         2: m_ctrl[v] = d & 32'h3F;
         default: ;
      endcase
   endtask

   // One sweep from a tick in cycle t0; an optional config write lands just
   // after voice wr_after has been processed.
   task automatic model_sweep(input int t0, input int wr_after, input int wv, input int wa, input int wd);
      int  src, old_acc, new_acc, c, s, t;
      bit  sync_hit, inv;
      exp_t e;
      for (int v = 0; v < V; v++) begin
         src = (v + V - 1) % V;
         c = m_ctrl[v];
         old_acc = m_acc[v];
         sync_hit = 1'b0;
`ifdef TONE_GENERATOR_MULTI_SYNC_EN
         sync_hit = (((c >> 4) & 1) == 1) && m_rise[src];
`endif
         new_acc = sync_hit ? 0 : (old_acc + m_freq[v]) % ACC_MOD;
         m_rise[v] = (old_acc < HALF) && (new_acc >= HALF);
         if ((((old_acc >> 19) & 1) == 0) && (((new_acc >> 19) & 1) == 1))
            m_lfsr[v] = lfsr_next(m_lfsr[v]);
         m_acc[v] = new_acc;

         if ((c & 15) == 0) s = 0;
         else begin
            s = 12'hFFF;
            if (c & 8) s &= (m_lfsr[v] >> 11) & 12'hFFF;
            if (c & 4) s &= ((new_acc >> 12) > m_pw[v]) ? 12'hFFF : 0;
            if (c & 2) s &= (new_acc >> 12) & 12'hFFF;
            if (c & 1) begin
               inv = ((new_acc >> 23) & 1) ^ ((((c >> 5) & 1) == 1) ? ((m_acc[src] >> 23) & 1) : 0);
               t = (new_acc >> 11) & 12'hFFF;
               if (inv) t ^= 12'hFFF;
               s &= t;
            end
         end
         e.voice = v; e.data = s; e.cyc = t0 + 2 + v;
         sb.push_back(e);
         if (v == wr_after) model_write(wv, wa, wd);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         n_checks++;
         $display("FAIL busy_timeout: busy still %0d after %0d cycles, required 0", busy, n);
      end
   endtask

   task automatic cfg_write(input int v, input int a, input int d);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_voice = VW'(v); cfg_addr = 2'(a); cfg_data = 16'(d);
      @(posedge clk); #1;
      cfg_we = 1'b0;
      model_write(v, a, d);
   endtask

   task automatic tick(input int wr_after, input int wv, input int wa, input int wd);
      @(posedge clk); #1;
      sample_tick = 1'b1;
      model_sweep(cyc, wr_after, wv, wa, wd);
      @(posedge clk); #1;
      sample_tick = 1'b0;
      if (wr_after >= 0) begin
         repeat (wr_after) begin @(posedge clk); #1; end
         cfg_we = 1'b1; cfg_voice = VW'(wv); cfg_addr = 2'(wa); cfg_data = 16'(wd);
         @(posedge clk); #1;
         cfg_we = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, v, a, d;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", int'(dout), 0);
      check("reset_valid", int'(dout_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_overrun", int'(overrun), 0);
      rst = 1'b1;

      // All voices silent at freq 0
      tick(-1, 0, 0, 0);
      check("busy_after_sweep", int'(busy), 0);

      // Voice 1 saw: top phase bits advance by freq>>12 each tick
      cfg_write(1, 0, 16'h1000);
      cfg_write(1, 2, 16'h0002);
      for (int k = 1; k <= 16; k++) begin
         tick(-1, 0, 0, 0);
         check("saw_voice1", last_dout[1], ((k * 32'h1000) >> 12) & 12'hFFF);
      end

      // Voice 2 pulse
      cfg_write(2, 1, 16'h07FF);
      cfg_write(2, 0, 16'h8000);
      cfg_write(2, 2, 16'h0004);
      for (int k = 0; k < 8; k++) tick(-1, 0, 0, 0);

      // Voice 0 triangle with ring mod from fast voice 3
      cfg_write(3, 0, 16'hFFFF);
      cfg_write(0, 0, 16'h0800);
      cfg_write(0, 2, 16'h0021);
      for (int k = 0; k < 200; k++) tick(-1, 0, 0, 0);

      // Voice 1 saw with sync from voice 0
      cfg_write(0, 0, 16'hFFFF);
      cfg_write(1, 2, 16'h0012);
      for (int k = 0; k < 300; k++) tick(-1, 0, 0, 0);

      // Randomized config/tick mix, including writes landing mid-sweep
      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 9);
         v = $urandom_range(0, V - 1);
         a = $urandom_range(0, 3);
         d = $urandom_range(0, 16'hFFFF);
         if (r < 4)      cfg_write(v, a, d);
         else if (r < 8) tick(-1, 0, 0, 0);
         else            tick($urandom_range(0, V - 1), v, a, d);
      end
      check("overrun_clear", int'(overrun), 0);

      // Tick held into the sweep: one sweep only, overrun becomes sticky
      @(posedge clk); #1;
      sample_tick = 1'b1;
      model_sweep(cyc, -1, 0, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      sample_tick = 1'b0;
      wait_idle();
      check("overrun_set", int'(overrun), 1);
      tick(-1, 0, 0, 0);
      check("overrun_held", int'(overrun), 1);

      // Asynchronous reset mid-sweep clears outputs before the next edge
      @(posedge clk); #1;
      sample_tick = 1'b1;
      model_sweep(cyc, -1, 0, 0, 0);
      @(posedge clk); #1;
      sample_tick = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check("arst_dout", int'(dout), 0);
      check("arst_voice", int'(dout_voice), 0);
      check("arst_valid", int'(dout_valid), 0);
      check("arst_busy", int'(busy), 0);
      check("arst_overrun", int'(overrun), 0);
      sb.delete();
      model_reset();
      @(posedge clk); #1;
      rst = 1'b1;

      // State cleared: everything silent again
      tick(-1, 0, 0, 0);
      tick(-1, 0, 0, 0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
